// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - shared CPU constants: exception codes, vector offsets, controller states
// Exception codes are 4 bits wide so that unused encodings can reach the controller as "unknown".
package cpu_defines;

  localparam int EXC_W = 4;

  typedef enum logic [EXC_W-1:0] {
    EXC_NO           = 4'd0,
    EXC_INTERRUPT    = 4'd1,
    EXC_SYSCALL      = 4'd2,
    EXC_INVALID_INST = 4'd3,
    EXC_OV           = 4'd4,
    EXC_BREAKPOINT   = 4'd5,
    EXC_ITLB_REFILL  = 4'd6,
    EXC_DTLB_REFILL  = 4'd7,
    EXC_TLB_INVALID  = 4'd8,
    EXC_ERET         = 4'd9
  } Excp_t;

  localparam logic [31:0] PC_INTERRUPT    = 32'h0000_0200;
  localparam logic [31:0] PC_SYSCALL      = 32'h0000_0180;
  localparam logic [31:0] PC_INVALID_INST = 32'h0000_0180;
  localparam logic [31:0] PC_OV           = 32'h0000_0180;
  localparam logic [31:0] PC_BREAKPOINT   = 32'h0000_0180;
  localparam logic [31:0] PC_TLB_REFILL   = 32'h0000_0000;
  localparam logic [31:0] PC_TLB_INVALID  = 32'h0000_0180;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/exc_vector_map.sv
// rtl/exc_vector_map.sv - maps an exception code to its redirect target
// Purely combinational so CP0 can share it; hit=0 means "no exception" (EXC_NO or unknown code).
module exc_vector_map
  import cpu_defines::*;
(
  input  logic [EXC_W-1:0] exc_code,
  input  logic [31:0]      cp0_ebase,
  input  logic [31:0]      cp0_epc,
  output logic             hit,
  output logic [31:0]      target
);

  always_comb begin
    hit    = 1'b1;
    target = 32'h0;
    case (exc_code)
      EXC_INTERRUPT:    target = cp0_ebase + PC_INTERRUPT;
      EXC_SYSCALL:      target = cp0_ebase + PC_SYSCALL;
      EXC_INVALID_INST: target = cp0_ebase + PC_INVALID_INST;
      EXC_OV:           target = cp0_ebase + PC_OV;
      EXC_BREAKPOINT:   target = cp0_ebase + PC_BREAKPOINT;
      EXC_ITLB_REFILL,
      EXC_DTLB_REFILL:  target = cp0_ebase + PC_TLB_REFILL;
      EXC_TLB_INVALID:  target = cp0_ebase + PC_TLB_INVALID;
      EXC_ERET:         target = cp0_epc;
      default:          hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_v2.sv
// rtl/pipe_ctrl_v2.sv - pipeline stall mask, exception redirect FSM and stall watchdog
// An exception seen during a bus stall is parked in WAIT_BUS and redirected once the bus frees.
module pipe_ctrl_v2
  import cpu_defines::*;
#(
  parameter int          NSTAGE        = 6,
  parameter int          STALL_TIMEOUT = 1024,
  parameter logic [31:0] RESET_PC      = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              bus_stall,
  input  logic              exc_valid,
  input  logic [EXC_W-1:0]  exc_code,
  input  logic [31:0]       cp0_ebase,
  input  logic [31:0]       cp0_epc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              exc_pending,
  output logic              stall_timeout
);

  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALL_TIMEOUT);

  ctrl_state_t       state_q, state_d;
  logic [31:0]       target_q, target_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic              flush_q, flush_d;
  logic              pending_q, pending_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              exc_hit;
  logic [31:0]       exc_target;
  logic [NSTAGE-1:0] req_mask;
  logic              seen;

  exc_vector_map u_vec (
    .exc_code  (exc_code),
    .cp0_ebase (cp0_ebase),
    .cp0_epc   (cp0_epc),
    .hit       (exc_hit),
    .target    (exc_target)
  );

  // A stalled stage forces every older stage (lower index) to hold as well.
  always_comb begin
    seen     = 1'b0;
    req_mask = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      seen        = seen | stallreq[i];
      req_mask[i] = seen;
    end
  end

  always_comb begin
    stall = '0;
    if (!rst) begin
      case (state_q)
        IDLE:     stall = bus_stall ? '1 : req_mask;
        WAIT_BUS: stall = '1;
        default:  stall = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (exc_valid && exc_hit) begin
          target_d = exc_target;
          if (bus_stall) begin
            state_d   = WAIT_BUS;
            pending_d = ENABLE;
          end else begin
            state_d = REDIRECT;
          end
        end
      end
      WAIT_BUS: begin
        if (!bus_stall) begin
          state_d   = REDIRECT;
          pending_d = DISABLE;
        end
      end
      default: state_d = IDLE;
    endcase
    flush_d  = (state_d == REDIRECT);
    new_pc_d = (state_d == REDIRECT) ? target_d : RESET_PC;
  end

  always_comb begin
    if (stall == '0) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= RESET_PC;
      new_pc_q  <= RESET_PC;
      flush_q   <= DISABLE;
      pending_q <= DISABLE;
      cnt_q     <= '0;
      timeout_q <= DISABLE;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      new_pc_q  <= new_pc_d;
      flush_q   <= flush_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign exc_pending   = pending_q;
  assign stall_timeout = timeout_q;

endmodule
